// File: rtl/usb_tx.sv
// USB low/full-speed transmitter: SYNC, NRZI + bit-stuffed data LSB first, EOP.
// Define USB_TX_KEEPALIVE_EN to add the `keepalive` input for bare LS keep-alive EOPs.
module usb_tx #(
  parameter int unsigned FS_DIV = 5,
  parameter int unsigned LS_DIV = 40
) (
  input  logic       clk60,
  input  logic       rst_n,
  input  logic       fullspeed,
  input  logic [7:0] din,
  input  logic       wrin,
  output logic       wrack,
  output logic       transmitting,
  output logic       oe,
  output logic       dp,
  output logic       dm
`ifdef USB_TX_KEEPALIVE_EN
  ,
  input  logic       keepalive
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SYNC = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_EOP0 = 3'd3;
  localparam logic [2:0] S_EOPJ = 3'd4;

  localparam logic [5:0] FS_LAST = 6'(FS_DIV - 1);
  localparam logic [5:0] LS_LAST = 6'(LS_DIV - 1);

  logic [2:0] state_q, state_d;
  logic [5:0] div_q, div_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [2:0] ones_q, ones_d;
  logic [7:0] data_q, data_d;
  logic       fs_q, fs_d;
  logic       wrack_q, wrack_d;
  logic       tx_q, tx_d;
  logic       oe_q, oe_d;
  logic       dp_q, dp_d;
  logic       dm_q, dm_d;
  logic       strobe;
  logic       pending;

  assign strobe  = (div_q == (fs_q ? FS_LAST : LS_LAST));
  assign pending = (wrin != wrack_q);

  always_comb begin
    state_d  = state_q;
    div_d    = '0;
    bitcnt_d = bitcnt_q;
    ones_d   = ones_q;
    data_d   = data_q;
    fs_d     = fs_q;
    wrack_d  = wrack_q;
    tx_d     = tx_q;
    oe_d     = oe_q;
    dp_d     = dp_q;
    dm_d     = dm_q;
    if (state_q == S_IDLE) begin
      if (pending) begin
        fs_d         = fullspeed;
        data_d       = din;
        wrack_d      = wrin;
        oe_d         = 1'b1;
        tx_d         = 1'b1;
        {dp_d, dm_d} = fullspeed ? 2'b10 : 2'b01;
        bitcnt_d     = '0;
        ones_d       = '0;
        state_d      = S_SYNC;
      end
`ifdef USB_TX_KEEPALIVE_EN
      // Keep-alive enters EOP0 already past its first strobe, so SE0 lasts two bits.
      else if (keepalive && !fullspeed) begin
        fs_d         = 1'b0;
        oe_d         = 1'b1;
        tx_d         = 1'b1;
        {dp_d, dm_d} = 2'b00;
        bitcnt_d     = 3'd1;
        ones_d       = '0;
        state_d      = S_EOP0;
      end
`endif
    end else begin
      div_d = strobe ? '0 : div_q + 6'd1;
      if (strobe) begin
        case (state_q)
          S_SYNC: begin
            if (bitcnt_q == 3'd7) begin
              ones_d   = 3'd1;
              bitcnt_d = '0;
              state_d  = S_DATA;
            end else begin
              {dp_d, dm_d} = {~dp_q, ~dm_q};
              ones_d       = '0;
              bitcnt_d     = bitcnt_q + 3'd1;
            end
          end
          S_DATA: begin
            // A stuffed toggle holds the bit counter so the same data bit goes out next.
            if (ones_q == 3'd6) begin
              {dp_d, dm_d} = {~dp_q, ~dm_q};
              ones_d       = '0;
            end else begin
              if (data_q[bitcnt_q]) begin
                ones_d = ones_q + 3'd1;
              end else begin
                {dp_d, dm_d} = {~dp_q, ~dm_q};
                ones_d       = '0;
              end
              if (bitcnt_q == 3'd7) begin
                bitcnt_d = '0;
                if (pending) begin
                  data_d  = din;
                  wrack_d = wrin;
                end else begin
                  state_d = S_EOP0;
                end
              end else begin
                bitcnt_d = bitcnt_q + 3'd1;
              end
            end
          end
          S_EOP0: begin
            if (bitcnt_q == 3'd0) begin
              if (ones_q == 3'd6) begin
                {dp_d, dm_d} = {~dp_q, ~dm_q};
                ones_d       = '0;
              end else begin
                {dp_d, dm_d} = 2'b00;
                ones_d       = '0;
                bitcnt_d     = 3'd1;
              end
            end else begin
              bitcnt_d = '0;
              state_d  = S_EOPJ;
            end
          end
          S_EOPJ: begin
            if (bitcnt_q == 3'd0) begin
              {dp_d, dm_d} = fs_q ? 2'b10 : 2'b01;
              bitcnt_d     = 3'd1;
            end else begin
              oe_d     = 1'b0;
              tx_d     = 1'b0;
              bitcnt_d = '0;
              state_d  = S_IDLE;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk60 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bitcnt_q <= '0;
      ones_q   <= '0;
      data_q   <= '0;
      fs_q     <= 1'b0;
      wrack_q  <= 1'b0;
      tx_q     <= 1'b0;
      oe_q     <= 1'b0;
      dp_q     <= 1'b0;
      dm_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bitcnt_q <= bitcnt_d;
      ones_q   <= ones_d;
      data_q   <= data_d;
      fs_q     <= fs_d;
      wrack_q  <= wrack_d;
      tx_q     <= tx_d;
      oe_q     <= oe_d;
      dp_q     <= dp_d;
      dm_q     <= dm_d;
    end
  end

  assign wrack        = wrack_q;
  assign transmitting = tx_q;
  assign oe           = oe_q;
  assign dp           = dp_q;
  assign dm           = dm_q;

endmodule
